// File: rtl/cpu_pkg.sv
// Shared definitions for the accumulator CPU: opcodes, sequencer states,
// instruction field positions and the registered control bundle.
package cpu_pkg;

    localparam int unsigned INSTR_W  = 16;
    localparam int unsigned OPC_W    = 4;
    localparam int unsigned OPND_W   = 12;
    localparam int unsigned OPC_LSB  = 12;
    localparam int unsigned OPND_LSB = 0;
    localparam int unsigned ALU_W    = OPC_W;

    localparam logic [OPC_W-1:0] OP_LDI   = 4'b1011;
    localparam logic [OPC_W-1:0] OP_STORE = 4'b0010;
    localparam logic [OPC_W-1:0] OP_JMP   = 4'b1110;
    localparam logic [OPC_W-1:0] OP_HALT  = 4'b1111;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        FETCH     = 3'd1,
        DECODE    = 3'd2,
        EXECUTE   = 3'd3,
        MEM       = 3'd4,
        WRITEBACK = 3'd5,
        HALTED    = 3'd6
    } seq_state_t;

    // Control outputs, registered as one bundle so they change only at clock edges
    typedef struct packed {
        logic             imem_req;
        logic [ALU_W-1:0] alu_mode;
        logic             mux2_sel;
        logic             dmem_we;
        logic             acc_we;
        logic             busy;
        logic             halted;
    } ctrl_t;

    function automatic logic [OPC_W-1:0] instr_opcode(input logic [INSTR_W-1:0] instr);
        return instr[OPC_LSB +: OPC_W];
    endfunction

    function automatic logic [OPND_W-1:0] instr_operand(input logic [INSTR_W-1:0] instr);
        return instr[OPND_LSB +: OPND_W];
    endfunction

endpackage

// File: rtl/pc_counter.sv
// Program counter: synchronous reset to START_ADDR, load, or modulo increment.
module pc_counter #(
    parameter int unsigned          PC_W       = 8,
    parameter logic [PC_W-1:0]      START_ADDR = '0
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            ld,
    input  logic [PC_W-1:0] ld_val,
    input  logic            inc,
    output logic [PC_W-1:0] pc
);

    // Reset wins, then load, then increment (wraps naturally at all-ones)
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pc <= START_ADDR;
        end else if (ld) begin
            pc <= ld_val;
        end else if (inc) begin
            pc <= pc + PC_W'(1);
        end
    end

endmodule

// File: rtl/instr_sequencer.sv
// Fetch/decode/execute sequencer for the accumulator CPU. Owns PC and IR and
// drives datapath strobes one phase at a time.
module instr_sequencer
    import cpu_pkg::*;
#(
    parameter int unsigned     PC_W       = 8,
    parameter logic [PC_W-1:0] START_ADDR = '0
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               run,
    output logic [PC_W-1:0]    imem_addr,
    output logic               imem_req,
    input  logic [INSTR_W-1:0] imem_data,
    input  logic               imem_valid,
    output logic [OPND_W-1:0]  ir_operand,
    output logic [ALU_W-1:0]   alu_mode,
    output logic               mux2_sel,
    output logic               dmem_we,
    input  logic               dmem_ready,
    output logic               acc_we,
    output logic               busy,
    output logic               halted
);

    seq_state_t         state;
    seq_state_t         state_nxt;
    logic [INSTR_W-1:0] ir;
    logic [INSTR_W-1:0] ir_nxt;
    logic [OPC_W-1:0]   opc;
    logic [OPC_W-1:0]   opc_nxt;
    logic               pc_ld;
    logic               pc_inc;
    logic [PC_W-1:0]    pc_ld_val;
    logic [PC_W-1:0]    pc;
    logic               exec_ph;
    ctrl_t              ctrl_nxt;
    ctrl_t              ctrl_q;

    assign opc = instr_opcode(ir);

    pc_counter #(
        .PC_W       (PC_W),
        .START_ADDR (START_ADDR)
    ) u_pc (
        .clk    (clk),
        .rst_n  (rst_n),
        .ld     (pc_ld),
        .ld_val (pc_ld_val),
        .inc    (pc_inc),
        .pc     (pc)
    );

    // Next state, IR capture and PC update requests
    always_comb begin
        state_nxt = state;
        ir_nxt    = ir;
        pc_ld     = 1'b0;
        pc_inc    = 1'b0;
        pc_ld_val = START_ADDR;
        case (state)
            IDLE, HALTED: begin
                if (run) begin
                    pc_ld     = 1'b1;
                    state_nxt = FETCH;
                end
            end
            FETCH: begin
                if (imem_valid) begin
                    ir_nxt    = imem_data;
                    state_nxt = DECODE;
                end
            end
            DECODE: begin
                if (opc == OP_JMP) begin
                    pc_ld     = 1'b1;
                    pc_ld_val = PC_W'(instr_operand(ir));
                    state_nxt = FETCH;
                end else if (opc == OP_HALT) begin
                    state_nxt = HALTED;
                end else begin
                    state_nxt = EXECUTE;
                end
            end
            EXECUTE: begin
                state_nxt = (opc == OP_STORE) ? MEM : WRITEBACK;
            end
            MEM: begin
                if (dmem_ready) begin
                    pc_inc    = 1'b1;
                    state_nxt = FETCH;
                end
            end
            WRITEBACK: begin
                pc_inc    = 1'b1;
                state_nxt = FETCH;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Control bundle decoded from the state/IR about to be registered
    always_comb begin
        ctrl_nxt          = '0;
        opc_nxt           = instr_opcode(ir_nxt);
        exec_ph           = (state_nxt == EXECUTE) || (state_nxt == WRITEBACK);
        ctrl_nxt.imem_req = (state_nxt == FETCH);
        ctrl_nxt.alu_mode = exec_ph ? opc_nxt : '0;
        ctrl_nxt.mux2_sel = exec_ph && (opc_nxt == OP_LDI);
        ctrl_nxt.dmem_we  = (state_nxt == MEM);
        ctrl_nxt.acc_we   = (state_nxt == WRITEBACK);
        ctrl_nxt.busy     = (state_nxt != IDLE) && (state_nxt != HALTED);
        ctrl_nxt.halted   = (state_nxt == HALTED);
    end

    // State, IR and control registers; reset clears any pending strobe
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state  <= IDLE;
            ir     <= '0;
            ctrl_q <= '0;
        end else begin
            state  <= state_nxt;
            ir     <= ir_nxt;
            ctrl_q <= ctrl_nxt;
        end
    end

    assign imem_addr  = pc;
    assign ir_operand = instr_operand(ir);
    assign imem_req   = ctrl_q.imem_req;
    assign alu_mode   = ctrl_q.alu_mode;
    assign mux2_sel   = ctrl_q.mux2_sel;
    assign dmem_we    = ctrl_q.dmem_we;
    assign acc_we     = ctrl_q.acc_we;
    assign busy       = ctrl_q.busy;
    assign halted     = ctrl_q.halted;

endmodule

// File: doc/instr_sequencer.md
Name: instr_sequencer

Overview:
Multi-cycle fetch/decode/execute controller for the 4-bit-opcode accumulator CPU. Owns the program counter and instruction register. Sequences instruction-memory fetches with a valid handshake. Drives the datapath controls (ALU mode, MUX2 select, data-memory write, accumulator write) one phase at a time, and handles STORE wait-states, JMP and HALT.

Parameters:
PC_W, 8, program counter / instruction address width
START_ADDR, 0, PC value loaded on reset and on each run start

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  synchronous active-low reset
run  in  1  start pulse; honoured only in IDLE or HALTED
imem_addr  out  PC_W  instruction address (= PC)
imem_req  out  1  fetch request
imem_data  in  16  instruction: [15:12] opcode, [11:0] operand
imem_valid  in  1  imem_data valid this cycle
ir_operand  out  12  operand field of the held instruction
alu_mode  out  4  ALU mode (= IR opcode in EXECUTE/WRITEBACK, else 0)
mux2_sel  out  1  1 = immediate operand to accumulator (LOAD imm)
dmem_we  out  1  data-memory write strobe
dmem_ready  in  1  data memory accepted write
acc_we  out  1  accumulator write-enable, single-cycle pulse
busy  out  1  high in any state except IDLE and HALTED
halted  out  1  high in HALTED

Behaviour:
- Reset is synchronous and active-low; one clock.
- rst_n low at a clock edge gives state IDLE, PC = START_ADDR, IR = 0. All outputs are 0 the following cycle. This applies mid-instruction too: no pending strobe survives.
- Opcodes: 1011 LDI, 0010 STORE, 1110 JMP, 1111 HALT. All others are ALU operations with writeback.
- IDLE: run=1 moves to FETCH.
- FETCH: imem_req=1, imem_addr=PC. Stay while imem_valid=0. On imem_valid=1, latch IR=imem_data and go to DECODE. imem_valid outside FETCH is ignored.
- DECODE (1 cycle):
  - JMP: PC = operand[PC_W-1:0], go to FETCH.
  - HALT: go to HALTED, PC unchanged.
  - Otherwise go to EXECUTE.
- EXECUTE (1 cycle): alu_mode = opcode; mux2_sel = (opcode==1011). STORE goes to MEM; all others go to WRITEBACK.
- MEM: dmem_we=1, held until dmem_ready=1. On that cycle, PC = PC+1 and go to FETCH. Each STORE produces exactly one dmem_we/dmem_ready overlap cycle.
- WRITEBACK (1 cycle): acc_we=1, alu_mode and mux2_sel held as in EXECUTE, PC = PC+1, go to FETCH.
- HALTED: all strobes 0, halted=1. run=1 sets PC = START_ADDR and goes to FETCH.
- run while busy is ignored.
- PC increments modulo 2^PC_W: all-ones wraps to 0 silently.
- Latency with zero-wait memories (imem_valid and dmem_ready already high):
  - ALU/LDI: 4 cycles.
  - STORE: 4 cycles.
  - JMP: 2 cycles.
  - HALT: 2 cycles to halted=1.
  - Each wait cycle adds 1.
- Control outputs are a pure decode of the registered state and IR, so they are glitch-free at register boundaries.
- Never assert dmem_we and acc_we together.

Decomposition:
- Shared package cpu_pkg holds:
  - opcode constants (OP_LDI, OP_STORE, OP_JMP, OP_HALT);
  - the state enum (IDLE, FETCH, DECODE, EXECUTE, MEM, WRITEBACK, HALTED);
  - the instruction field positions.
- One natural sub-module: pc_counter (load, increment, reset to START_ADDR, PC_W wide).

Test Plan:
- Reset then run; imem returns LDI 0x005 at addr 0 with immediate imem_valid -> cycles: FETCH, DECODE, EXECUTE (mux2_sel=1, alu_mode=1011), WRITEBACK (acc_we=1 for one cycle); imem_addr=1 on cycle 5.
- STORE at addr 1, dmem_ready delayed 3 cycles -> dmem_we high exactly 4 cycles, acc_we never set, next imem_addr=2.
- JMP 0x0F0 -> next imem_req with imem_addr=0xF0 two cycles after fetch; no alu_mode or acc_we activity.
- PC_W=8, ALU op (0001) at 0xFF -> following fetch at 0x00.
- HALT -> halted=1 and busy=0 with PC held; run pulse -> fetch at START_ADDR. run pulses during busy -> no effect.
- rst_n low during MEM with dmem_we=1 -> next cycle dmem_we=0, state IDLE, imem_addr=START_ADDR; imem_valid while IDLE -> no IR change.
